slot_alloc_tracker: RTL

- Keeps a registered occupancy bitmap of WIDTH hardware slots (buffer entries, channel contexts) and hands out free slot indices on request.
- Allocation picks the highest-numbered free slot (MSB-zero priority). Release decodes an index back into a one-hot clear of the bitmap.
- Sits between SPU request logic and the slot-owning datapath. It is the single owner of the busy/free state.

---
 rtl/slot_alloc_tracker.sv | 108 ++++++++++
 1 files changed

// File: rtl/slot_alloc_tracker.sv
// slot_alloc_tracker
//   Tracks which of WIDTH hardware slots are in use and hands out free slot
//   indices on request. An allocation takes the highest-numbered free slot.
//   A release clears one slot by index. A flush frees every slot. This block
//   is the only owner of the busy/free state.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   alloc_req  request one slot this cycle
//   alloc_ack  registered pulse: grant made, alloc_idx valid
//   alloc_nak  registered pulse: request refused (full or flush)
//   alloc_idx  last granted slot index, held until the next grant
//   rel_req    release slot rel_idx this cycle
//   rel_idx    slot to release
//   rel_err    registered pulse: illegal release, ignored
//   flush      free all slots
//   busy_map   occupancy bitmap, bit i set = slot i in use
//   count      number of occupied slots, 0..WIDTH
//   full       count == WIDTH
//   empty      count == 0
module slot_alloc_tracker #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ack,
  output logic             alloc_nak,
  output logic [IDXW-1:0]  alloc_idx,
  input  logic             rel_req,
  input  logic [IDXW-1:0]  rel_idx,
  output logic             rel_err,
  input  logic             flush,
  output logic [WIDTH-1:0] busy_map,
  output logic [IDXW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam logic [IDXW-1:0]  FULL_CNT = IDXW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);

  // Highest index whose bit is clear. Ascending scan so the last hit wins.
  function automatic logic [IDXW-1:0] find_free(input logic [WIDTH-1:0] m);
    logic [IDXW-1:0] sel;
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!m[i]) sel = IDXW'(i);
    end
    return sel;
  endfunction

  logic [IDXW-1:0]  sel_p0;
  logic             grant_p0;
  logic [WIDTH-1:0] set_mask_p0;
  logic             rel_in_range_p0;
  logic [WIDTH-1:0] rel_onehot_p0;
  logic             rel_legal_p0;
  logic [WIDTH-1:0] clr_mask_p0;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_comb begin
    sel_p0          = find_free(busy_map);
    grant_p0        = alloc_req && !full && !flush;
    set_mask_p0     = grant_p0 ? (ONE_HOT0 << sel_p0) : '0;
    // Out-of-range indices decode to an empty mask, so they never look legal.
    rel_in_range_p0 = (rel_idx < FULL_CNT);
    rel_onehot_p0   = rel_in_range_p0 ? (ONE_HOT0 << rel_idx) : '0;
    rel_legal_p0    = rel_req && |(rel_onehot_p0 & busy_map);
    // Flush drops a concurrent release without reporting it.
    clr_mask_p0     = (rel_legal_p0 && !flush) ? rel_onehot_p0 : '0;
  end

  // ---- registered state and pulses (stage p0 -> outputs) ----
  // The granted bit is free and the released bit is busy before the edge,
  // so set and clear masks never overlap and can be applied together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_map  <= '0;
      count     <= '0;
      alloc_idx <= '0;
      alloc_ack <= 1'b0;
      alloc_nak <= 1'b0;
      rel_err   <= 1'b0;
    end else begin
      alloc_ack <= grant_p0;
      alloc_nak <= alloc_req && !grant_p0;
      rel_err   <= rel_req && !flush && !rel_legal_p0;
      if (grant_p0) alloc_idx <= sel_p0;
      if (flush) begin
        busy_map <= '0;
        count    <= '0;
      end else begin
        busy_map <= (busy_map & ~clr_mask_p0) | set_mask_p0;
        case ({grant_p0, |clr_mask_p0})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
